change_dispenser: RTL and testbench

//  Settlement/payout side of the vending path: on a purchase request, checks the

---
 rtl/change_dispenser.sv | 250 +++++++++++++++++++++++++
 tb/tb_change_dispenser.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
`timescale 1ns/1ps
// ============================================================================
// change_dispenser
//
// Settlement and payout stage of the vending path. A purchase request compares
// the credited total with the selected price and then rejects or accepts the
// purchase. On accept, the change is paid out to a coin ejector as a greedy
// sequence of coins over a valid/ready handshake. Money is in 0.1-unit steps,
// so 5 means 0.5 and 130 means 13.0.
//
// Parameters
//   DEN0..DEN3   coin values for coin_type 0..3, largest first
//   TIMEOUT      maximum number of cycles coin_valid may wait for coin_ready
//
// Ports
//   CLK100MHZ     in   1  system clock
//   RST           in   1  synchronous, active-high reset
//   buy_req       in   1  purchase request, sampled only while idle
//   total_money   in   8  credited amount, latched on an accepted buy_req
//   item_price    in   8  selected price, latched with total_money; 0 = no item
//   buy_ack       out  1  one-cycle pulse: purchase accepted
//   buy_reject    out  1  one-cycle pulse: no item, or not enough credit
//   coin_valid    out  1  coin_type is valid; held until the handshake
//   coin_type     out  2  denomination index to eject; stable while coin_valid
//   coin_ready    in   1  ejector accepts the coin (handshake = valid & ready)
//   change_left   out  8  change still owed
//   coin_count    out  4  coins ejected in this transaction, saturates at 15
//   busy          out  1  high whenever a transaction is in progress
//   done          out  1  one-cycle pulse: transaction finished
//   short_change  out  1  pulses with done when a residue below DEN3 is left
//   fault         out  1  sticky ejector timeout, cleared only by RST
// ============================================================================
module change_dispenser #(
    parameter int DEN0    = 100,
    parameter int DEN1    = 50,
    parameter int DEN2    = 10,
    parameter int DEN3    = 5,
    parameter int TIMEOUT = 1000000
) (
    input  logic       CLK100MHZ,
    input  logic       RST,
    input  logic       buy_req,
    input  logic [7:0] total_money,
    input  logic [7:0] item_price,
    output logic       buy_ack,
    output logic       buy_reject,
    output logic       coin_valid,
    output logic [1:0] coin_type,
    input  logic       coin_ready,
    output logic [7:0] change_left,
    output logic [3:0] coin_count,
    output logic       busy,
    output logic       done,
    output logic       short_change,
    output logic       fault
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CHECK  = 2'd1;
    localparam logic [1:0] SELECT = 2'd2;
    localparam logic [1:0] ISSUE  = 2'd3;

    // Coin values at the width of the money datapath.
    localparam logic [7:0] D0 = 8'(DEN0);
    localparam logic [7:0] D1 = 8'(DEN1);
    localparam logic [7:0] D2 = 8'(DEN2);
    localparam logic [7:0] D3 = 8'(DEN3);

    // The wait counter only has to reach TIMEOUT-1.
    localparam int              CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT - 1);

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    function automatic logic [7:0] den_of(input logic [1:0] idx);
        logic [7:0] val;
        case (idx)
            2'd0:    val = D0;
            2'd1:    val = D1;
            2'd2:    val = D2;
            default: val = D3;
        endcase
        return val;
    endfunction

    // Largest coin not exceeding amt. Only called when amt >= D3, so the
    // fall-through to the smallest coin is always a legal payout.
    function automatic logic [1:0] pick_coin(input logic [7:0] amt);
        logic [1:0] idx;
        if (amt >= D0)      idx = 2'd0;
        else if (amt >= D1) idx = 2'd1;
        else if (amt >= D2) idx = 2'd2;
        else                idx = 2'd3;
        return idx;
    endfunction

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [1:0]    state;
    logic [7:0]    total_q;
    logic [7:0]    price_q;
    logic [CW-1:0] wait_cnt;

    // Next-state values
    logic [1:0]    state_n;
    logic [7:0]    total_n;
    logic [7:0]    price_n;
    logic [CW-1:0] wait_cnt_n;
    logic          buy_ack_n;
    logic          buy_reject_n;
    logic          coin_valid_n;
    logic [1:0]    coin_type_n;
    logic [7:0]    change_left_n;
    logic [3:0]    coin_count_n;
    logic          done_n;
    logic          short_change_n;
    logic          fault_n;

    logic          handshake;

    // coin_valid is only ever high in ISSUE, so this is the full handshake.
    assign handshake = coin_valid & coin_ready;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_n        = state;
        total_n        = total_q;
        price_n        = price_q;
        wait_cnt_n     = wait_cnt;
        coin_valid_n   = coin_valid;
        coin_type_n    = coin_type;
        change_left_n  = change_left;
        coin_count_n   = coin_count;
        fault_n        = fault;
        // Pulse outputs fall back to zero every cycle.
        buy_ack_n      = 1'b0;
        buy_reject_n   = 1'b0;
        done_n         = 1'b0;
        short_change_n = 1'b0;

        case (state)
            IDLE: begin
                // A faulted dispenser refuses new work until reset.
                if (buy_req && !fault) begin
                    total_n      = total_money;
                    price_n      = item_price;
                    coin_count_n = 4'd0;
                    state_n      = CHECK;
                end
            end

            CHECK: begin
                if ((price_q == 8'd0) || (total_q < price_q)) begin
                    buy_reject_n = 1'b1;
                    state_n      = IDLE;
                end else begin
                    buy_ack_n     = 1'b1;
                    change_left_n = total_q - price_q;
                    state_n       = SELECT;
                end
            end

            SELECT: begin
                if (change_left == 8'd0) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (change_left < D3) begin
                    // Residue smaller than any coin: finish and flag it.
                    done_n         = 1'b1;
                    short_change_n = 1'b1;
                    state_n        = IDLE;
                end else begin
                    coin_type_n  = pick_coin(change_left);
                    coin_valid_n = 1'b1;
                    wait_cnt_n   = '0;
                    state_n      = ISSUE;
                end
            end

            ISSUE: begin
                if (handshake) begin
                    change_left_n = change_left - den_of(coin_type);
                    coin_count_n  = (coin_count == 4'hF) ? coin_count
                                                         : coin_count + 4'd1;
                    coin_valid_n  = 1'b0;
                    state_n       = SELECT;
                end else if (wait_cnt == TO_LAST) begin
                    // Ejector stuck: abandon, keep the unpaid amount visible.
                    fault_n      = 1'b1;
                    coin_valid_n = 1'b0;
                    state_n      = IDLE;
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK100MHZ) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the values from before this edge, independent of statement order.
        if (RST) begin
            state        <= IDLE;
            total_q      <= 8'd0;
            price_q      <= 8'd0;
            wait_cnt     <= '0;
            buy_ack      <= 1'b0;
            buy_reject   <= 1'b0;
            coin_valid   <= 1'b0;
            coin_type    <= 2'd0;
            change_left  <= 8'd0;
            coin_count   <= 4'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            short_change <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state        <= state_n;
            total_q      <= total_n;
            price_q      <= price_n;
            wait_cnt     <= wait_cnt_n;
            buy_ack      <= buy_ack_n;
            buy_reject   <= buy_reject_n;
            coin_valid   <= coin_valid_n;
            coin_type    <= coin_type_n;
            change_left  <= change_left_n;
            coin_count   <= coin_count_n;
            // busy is registered from the next state so it tracks state exactly.
            busy         <= (state_n != IDLE);
            done         <= done_n;
            short_change <= short_change_n;
            fault        <= fault_n;
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
`timescale 1ns/1ps
// ============================================================================
// tb_change_dispenser
//
// Self-checking bench for change_dispenser. Directed scenarios cover accept,
// reject, exact payment, short change, ejector timeout and reset mid-payout;
// a randomized loop follows. Expected coins come from a greedy reference model
// computed with plain arithmetic over the denomination table.
// ============================================================================
module tb_change_dispenser;

    localparam int TIMEOUT = 16;
    localparam int DENS [4] = '{100, 50, 10, 5};

    logic       clk;
    logic       rst;
    logic       buy_req;
    logic [7:0] total_money;
    logic [7:0] item_price;
    logic       buy_ack;
    logic       buy_reject;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       coin_ready;
    logic [7:0] change_left;
    logic [3:0] coin_count;
    logic       busy;
    logic       done;
    logic       short_change;
    logic       fault;

    int checks = 0;
    int errors = 0;

    change_dispenser #(
        .DEN0    (100),
        .DEN1    (50),
        .DEN2    (10),
        .DEN3    (5),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK100MHZ    (clk),
        .RST          (rst),
        .buy_req      (buy_req),
        .total_money  (total_money),
        .item_price   (item_price),
        .buy_ack      (buy_ack),
        .buy_reject   (buy_reject),
        .coin_valid   (coin_valid),
        .coin_type    (coin_type),
        .coin_ready   (coin_ready),
        .change_left  (change_left),
        .coin_count   (coin_count),
        .busy         (busy),
        .done         (done),
        .short_change (short_change),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},    buy_ack,      0);
        check({tag, "_rej"},    buy_reject,   0);
        check({tag, "_valid"},  coin_valid,   0);
        check({tag, "_type"},   coin_type,    0);
        check({tag, "_change"}, change_left,  0);
        check({tag, "_count"},  coin_count,   0);
        check({tag, "_busy"},   busy,         0);
        check({tag, "_done"},   done,         0);
        check({tag, "_short"},  short_change, 0);
        check({tag, "_fault"},  fault,        0);
    endtask

    // Reference model: greedy coin list for an amount of change.
    task automatic greedy(input int amount, output int coins[$], output int residue);
        int rem;
        coins = {};
        rem   = amount;
        while (rem >= DENS[3]) begin
            for (int i = 0; i < 4; i++) begin
                if (DENS[i] <= rem) begin
                    coins.push_back(i);
                    rem -= DENS[i];
                    break;
                end
            end
        end
        residue = rem;
    endtask

    // One full purchase. tied keeps coin_ready high throughout; otherwise the
    // ejector stalls a random 0..max_stall cycles per coin.
    task automatic run_purchase(input string tag, input int total, input int price,
                                input bit tied, input int max_stall);
        int  coins[$];
        int  residue;
        int  rem;
        int  cnt;
        int  stall;
        bit  accept;

        accept = (price != 0) && (total >= price);

        @(negedge clk);
        buy_req     = 1'b1;
        total_money = 8'(total);
        item_price  = 8'(price);
        coin_ready  = tied;
        step();                                 // edge 0 latches the request
        buy_req     = 1'b0;
        total_money = 8'($urandom);             // must not affect the transaction
        item_price  = 8'($urandom);
        check({tag, "_busy_e0"}, busy, 1);
        check({tag, "_ack_e0"},  buy_ack, 0);

        step();                                 // edge 1: decision
        check({tag, "_ack"},    buy_ack,    accept);
        check({tag, "_reject"}, buy_reject, !accept);

        if (!accept) begin
            step();
            check({tag, "_rj_busy"},  busy,       0);
            check({tag, "_rj_valid"}, coin_valid, 0);
            check({tag, "_rj_done"},  done,       0);
            check({tag, "_rj_pulse"}, buy_reject, 0);
            coin_ready = 1'b0;
            return;
        end

        greedy(total - price, coins, residue);
        rem = total - price;
        cnt = 0;
        check({tag, "_change0"}, change_left, rem);
        check({tag, "_count0"},  coin_count,  0);

        foreach (coins[i]) begin
            step();                             // coin presented
            check({tag, "_valid"}, coin_valid, 1);
            check({tag, "_type"},  coin_type,  coins[i]);
            check({tag, "_nodone"}, done, 0);
            if (!tied) begin
                stall = $urandom_range(0, max_stall);
                for (int s = 0; s < stall; s++) begin
                    step();
                    check({tag, "_hold_v"}, coin_valid, 1);
                    check({tag, "_hold_t"}, coin_type,  coins[i]);
                end
                coin_ready = 1'b1;
            end
            step();                             // handshake edge
            if (!tied) coin_ready = 1'b0;
            rem -= DENS[coins[i]];
            cnt++;
            check({tag, "_gap_v"},  coin_valid,  0);
            check({tag, "_left"},   change_left, rem);
            check({tag, "_count"},  coin_count,  (cnt > 15) ? 15 : cnt);
        end

        step();                                 // done
        check({tag, "_done"},       done,         1);
        check({tag, "_short"},      short_change, residue != 0);
        check({tag, "_final_left"}, change_left,  residue);
        check({tag, "_final_cnt"},  coin_count,   coins.size());
        check({tag, "_final_v"},    coin_valid,   0);
        check({tag, "_final_busy"}, busy,         0);
        step();
        check({tag, "_done_pulse"}, done, 0);
        coin_ready = 1'b0;
    endtask

    initial begin
        int n;
        int total;
        int price;

        rst         = 1'b1;
        buy_req     = 1'b0;
        total_money = 8'd0;
        item_price  = 8'd0;
        coin_ready  = 1'b0;

        // Reset state
        step();
        step();
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed scenarios
        run_purchase("t1_200_65",  200, 65,  1'b1, 0);
        run_purchase("t2_10_15",   10,  15,  1'b0, 0);
        run_purchase("t3_20_20",   20,  20,  1'b0, 0);
        run_purchase("t4_137_130", 137, 130, 1'b0, 2);
        run_purchase("price0",     90,  0,   1'b0, 0);
        run_purchase("max_255_1",  255, 1,   1'b0, 3);

        // Ejector timeout
        @(negedge clk);
        buy_req     = 1'b1;
        total_money = 8'd130;
        item_price  = 8'd5;
        coin_ready  = 1'b0;
        step();
        buy_req = 1'b0;
        step();
        check("to_ack", buy_ack, 1);
        step();
        check("to_valid", coin_valid, 1);
        check("to_type",  coin_type,  0);
        n = 1;
        while (coin_valid && n < 100) begin
            step();
            if (coin_valid) n++;
        end
        check("to_cycles", n, TIMEOUT);
        check("to_fault",  fault,       1);
        check("to_valid0", coin_valid,  0);
        check("to_left",   change_left, 125);
        check("to_busy",   busy,        0);

        // Requests are ignored while faulted
        buy_req     = 1'b1;
        total_money = 8'd50;
        item_price  = 8'd10;
        for (int i = 0; i < 4; i++) begin
            step();
            check("flt_busy", busy,       0);
            check("flt_ack",  buy_ack,    0);
            check("flt_rej",  buy_reject, 0);
            check("flt_stky", fault,      1);
        end
        buy_req = 1'b0;
        rst     = 1'b1;
        step();
        rst     = 1'b0;
        check_all_zero("flt_rst");

        // Reset in the middle of a payout
        @(negedge clk);
        buy_req     = 1'b1;
        total_money = 8'd200;
        item_price  = 8'd10;
        coin_ready  = 1'b0;
        step();
        buy_req = 1'b0;
        step();
        step();
        check("mid_valid", coin_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("mid_rst");
        run_purchase("after_rst", 75, 20, 1'b0, 1);

        // Randomized purchases
        for (int i = 0; i < 30; i++) begin
            total = $urandom_range(0, 255);
            if (i % 3 == 0) price = $urandom_range(0, 255);
            else            price = $urandom_range(0, total);
            run_purchase($sformatf("rnd%0d", i), total, price,
                         1'($urandom_range(0, 1)), 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
